can_tx_sched: RTL



---
 rtl/can_tx_sched_pkg.sv | 14 +
 rtl/can_tx_prio_sel.sv | 33 +++
 rtl/can_tx_sched.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_sched_pkg.sv
// Shared types and widths for the CAN transmit mailbox scheduler.
package can_tx_sched_pkg;

    localparam int unsigned CAN_ID_W   = 11;
    localparam int unsigned CAN_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        REQ,
        BUSY
    } state_t;

endpackage

// File: rtl/can_tx_prio_sel.sv
// Combinational winner finder: lowest CAN ID among pending mailboxes, lowest index on a tie.
module can_tx_prio_sel
    import can_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]                pending_i,
    input  logic [NUM_MB-1:0][CAN_ID_W-1:0]  ids_i,
    output logic [$clog2(NUM_MB)-1:0]        idx_o,
    output logic                             valid_o
);

    localparam int unsigned IDX_W = $clog2(NUM_MB);

    logic                found;
    logic [CAN_ID_W-1:0] best_id;

    // Strict less-than keeps the earlier (lower) index when IDs are equal.
    always_comb begin
        found   = 1'b0;
        best_id = '1;
        idx_o   = '0;
        for (int unsigned i = 0; i < NUM_MB; i++) begin
            if (pending_i[i] && (!found || ids_i[i] < best_id)) begin
                found   = 1'b1;
                best_id = ids_i[i];
                idx_o   = IDX_W'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/can_tx_sched.sv
// Transmit mailbox scheduler driving can_tx; picks the lowest pending ID and tracks frame outcome.
// Optional: define CAN_TX_SCHED_RETRY_LIMIT_EN to give up on a mailbox after RETRY_LIMIT arbitration losses.
module can_tx_sched
    import can_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_MB      = 4,
    parameter int unsigned REQ_TIMEOUT = 1024,
    parameter int unsigned RETRY_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_MB)-1:0] wr_idx,
    input  logic [CAN_ID_W-1:0]       wr_addr,
    input  logic [CAN_DATA_W-1:0]     wr_data,
    input  logic                      abort_en,
    input  logic [$clog2(NUM_MB)-1:0] abort_idx,
    input  logic                      txing,
    input  logic                      arb_lost,
    output logic [CAN_ID_W-1:0]       address,
    output logic [CAN_DATA_W-1:0]     data,
    output logic                      send_data,
    output logic [NUM_MB-1:0]         mb_pending,
    output logic [NUM_MB-1:0]         mb_done,
    output logic [NUM_MB-1:0]         mb_fail
);

    localparam int unsigned IDX_W = $clog2(NUM_MB);
    localparam int unsigned TO_W  = $clog2(REQ_TIMEOUT + 1);

    if (NUM_MB < 2 || NUM_MB > 8 || REQ_TIMEOUT < 2 || RETRY_LIMIT < 1) begin : g_param_chk
        $error("can_tx_sched: parameter out of range");
    end

    state_t                              state_q, state_d;
    logic [NUM_MB-1:0]                   pending_q, pending_d;
    logic [NUM_MB-1:0][CAN_ID_W-1:0]     id_q, id_d;
    logic [NUM_MB-1:0][CAN_DATA_W-1:0]   pl_q, pl_d;
    logic [IDX_W-1:0]                    cur_q, cur_d;
    logic                                lost_q, lost_d;
    logic                                abort_q, abort_d;
    logic [TO_W-1:0]                     to_q, to_d;
    logic [CAN_ID_W-1:0]                 addr_q, addr_d;
    logic [CAN_DATA_W-1:0]               data_q, data_d;
    logic                                send_q, send_d;
    logic [NUM_MB-1:0]                   done_q, done_d;
    logic [NUM_MB-1:0]                   fail_q, fail_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);
    logic [RETRY_W-1:0]                  retry_q, retry_d;
`endif

    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic [IDX_W-1:0] cur_now;
    logic             abort_hit;
    logic             abort_cur;
    logic             frame_ok;
    logic             give_up;

    can_tx_prio_sel #(.NUM_MB(NUM_MB)) u_prio_sel (
        .pending_i (pending_q),
        .ids_i     (id_q),
        .idx_o     (win_idx),
        .valid_o   (win_valid)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        id_d      = id_q;
        pl_d      = pl_q;
        cur_d     = cur_q;
        lost_d    = lost_q;
        abort_d   = abort_q;
        to_d      = to_q;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = '0;
        fail_d    = '0;
        frame_ok  = 1'b0;
        give_up   = 1'b0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
        retry_d   = retry_q;
`endif

        // In SELECT the mailbox being latched already counts as current.
        cur_now   = (state_q == SELECT) ? win_idx : cur_q;
        abort_hit = abort_en && pending_q[abort_idx];
        abort_cur = abort_hit && (state_q != IDLE) && (abort_idx == cur_now);

        if (wr_en && !pending_q[wr_idx] && !(abort_en && abort_idx == wr_idx)) begin
            id_d[wr_idx]      = wr_addr;
            pl_d[wr_idx]      = wr_data;
            pending_d[wr_idx] = 1'b1;
        end

        if (abort_hit) begin
            if (abort_cur && state_q == BUSY) begin
                abort_d = 1'b1;
            end else begin
                pending_d[abort_idx] = 1'b0;
                fail_d[abort_idx]    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (|pending_q) state_d = SELECT;
            end
            SELECT: begin
                if (!win_valid || abort_cur) begin
                    state_d = IDLE;
                end else begin
                    cur_d   = win_idx;
                    addr_d  = id_q[win_idx];
                    data_d  = pl_q[win_idx];
                    lost_d  = 1'b0;
                    abort_d = 1'b0;
                    to_d    = '0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
                    if (win_idx != cur_q) retry_d = '0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                if (abort_cur) begin
                    state_d = IDLE;
                end else if (txing) begin
                    state_d = BUSY;
                end else if (to_q == TO_W'(REQ_TIMEOUT - 1)) begin
                    state_d = SELECT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            BUSY: begin
                if (arb_lost) lost_d = 1'b1;
                if (!txing) begin
                    state_d  = IDLE;
                    frame_ok = !(lost_q || arb_lost);
                    give_up  = abort_q || abort_cur;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
                    if (!frame_ok && retry_q == RETRY_W'(RETRY_LIMIT - 1)) give_up = 1'b1;
                    retry_d = (frame_ok || give_up) ? '0 : retry_q + 1'b1;
`endif
                    if (frame_ok) begin
                        pending_d[cur_q] = 1'b0;
                        done_d[cur_q]    = 1'b1;
                    end else if (give_up) begin
                        pending_d[cur_q] = 1'b0;
                        fail_d[cur_q]    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        send_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            id_q      <= '0;
            pl_q      <= '0;
            cur_q     <= '0;
            lost_q    <= 1'b0;
            abort_q   <= 1'b0;
            to_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            send_q    <= 1'b0;
            done_q    <= '0;
            fail_q    <= '0;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            pl_q      <= pl_d;
            cur_q     <= cur_d;
            lost_q    <= lost_d;
            abort_q   <= abort_d;
            to_q      <= to_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            send_q    <= send_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign address    = addr_q;
    assign data       = data_q;
    assign send_data  = send_q;
    assign mb_pending = pending_q;
    assign mb_done    = done_q;
    assign mb_fail    = fail_q;

endmodule
